// File: rtl/start_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : start_pkg
//  Description : Shared constants and helpers for the sticky start flag and
//                its optional input synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package start_pkg;

    // Deepest synchronizer chain the flag supports.
    localparam int START_SYNC_MAX = 4;

    // Value the flag and every synchronizer flop take while reset is asserted.
    localparam logic START_FLAG_RST = 1'b0;

    // True when a requested synchronizer depth can be built.
    function automatic bit sync_stages_ok(input int n);
        return (n >= 0) && (n <= START_SYNC_MAX);
    endfunction

endpackage : start_pkg
`default_nettype wire

// File: rtl/start_reg_flag_sync.sv
`default_nettype none
// ============================================================================
//  Module      : start_sync
//  Description : Parameterized flop chain bringing an asynchronous start
//                strobe into the clk domain. Every stage clears on reset so a
//                request still in flight when reset arrives is discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module start_sync
    import start_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw strobe one stage further down the chain every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= {STAGES{START_FLAG_RST}};
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule : start_sync
`default_nettype wire

// File: rtl/start_reg_flag.sv
`default_nettype none
// ============================================================================
//  Module      : start_reg_flag
//  Description : Sticky start flag. Captures the first start request after
//                reset and holds it as a level "run enabled" indication until
//                the next reset. An optional synchronizer chain on the start
//                input allows the strobe to come from an asynchronous source.
//  Revision    : 1.0 - initial release
// ============================================================================
module start_reg_flag
    import start_pkg::*;
#(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic out
);

    logic w_start_eff;
    logic w_out_next;
    logic r_out;

    // Reject synchronizer depths the chain is not meant to support.
    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("start_reg_flag: SYNC_STAGES=%0d outside 0..%0d",
               SYNC_STAGES, START_SYNC_MAX);
    end

    // Either resynchronize the strobe or use it directly.
    if (SYNC_STAGES > 0) begin : g_sync
        start_sync #(
            .STAGES (SYNC_STAGES)
        ) u_start_sync (
            .clk (clk),
            .rst (rst),
            .i_d (start),
            .o_q (w_start_eff)
        );
    end else begin : g_nosync
        assign w_start_eff = start;
    end

    // Once set, the flag can only be cleared by reset.
    assign w_out_next = r_out | w_start_eff;

    // Flag register: async clear, sticky set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= START_FLAG_RST;
        end else begin
            r_out <= w_out_next;
        end
    end

    assign out = r_out;

`ifndef SYNTHESIS
    // The flag must never fall while reset is deasserted.
    a_out_sticky : assert property (
        @(posedge clk) disable iff (rst) $past(r_out) |-> r_out
    );
`endif

endmodule : start_reg_flag
`default_nettype wire

// File: tb/tb_start_reg_flag.sv
`default_nettype none
// ============================================================================
//  Module      : tb_start_reg_flag
//  Description : Self-checking bench for start_reg_flag. Two instances run in
//                parallel (no synchronizer and a two-stage synchronizer) from
//                the same stimulus. Expected flag values come from a history
//                based reference model and are queued per clock edge; a
//                monitor pops and compares after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_start_reg_flag;

    localparam int c_S_A = 0;
    localparam int c_S_B = 2;

    logic clk;
    logic rst;
    logic start;
    logic out_a;
    logic out_b;

    int n_vec;
    int n_err;

    // Reference-model state: one entry per rising edge.
    bit start_hist[$];
    bit rst_hist[$];
    int epoch_hist[$];
    int epoch;
    bit prev_rst;

    // Scoreboard queues of expected flag values after each edge.
    bit q_a[$];
    bit q_b[$];

    start_reg_flag #(.SYNC_STAGES(c_S_A)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .out   (out_a)
    );

    start_reg_flag #(.SYNC_STAGES(c_S_B)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .out   (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The flag after the latest edge is 1 exactly when some start sampled
    // (reset low) at an edge at least S edges ago belongs to the current
    // reset epoch, and reset is low now.
    function automatic bit model_out(input int s);
        int n;
        n = start_hist.size() - 1;
        if (rst) return 1'b0;
        for (int k = 0; k <= n - s; k++) begin
            if (start_hist[k] && !rst_hist[k] && epoch_hist[k] == epoch)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic act, input bit exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Drive one clock's worth of inputs between edges and queue what both
    // instances must show after the following rising edge.
    task automatic step(input bit s, input bit r);
        @(negedge clk);
        rst   = r;
        start = s;
        if (r && !prev_rst) begin
            epoch++;
            #1;
            check("async_clear_s0", out_a, 1'b0);
            check("async_clear_s2", out_b, 1'b0);
        end
        prev_rst = r;
        start_hist.push_back(s);
        rst_hist.push_back(r);
        epoch_hist.push_back(epoch);
        q_a.push_back(model_out(c_S_A));
        q_b.push_back(model_out(c_S_B));
    endtask

    // Monitor: compare both outputs shortly after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) check("flag_s0", out_a, q_a.pop_front());
            if (q_b.size() > 0) check("flag_s2", out_b, q_b.pop_front());
        end
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        epoch    = 0;
        prev_rst = 1'b1;
        rst      = 1'b1;
        start    = 1'b0;

        // Power-on reset, then release with start low.
        step(0, 1); step(0, 1);
        step(0, 0); step(0, 0);
        // Single start pulse, then flag must hold.
        step(1, 0);
        repeat (5) step(0, 0);
        // Asynchronous clear while set, release with start low.
        step(0, 1); step(0, 1);
        step(0, 0); step(0, 0); step(0, 0);
        // Reset dominance with start held high through release.
        step(1, 1); step(1, 1); step(1, 1);
        step(1, 0); step(0, 0); step(0, 0); step(0, 0);
        // Repeated pulses after the flag is set.
        repeat (3) begin
            step(1, 0); step(0, 0);
        end
        // Reset while a pulse is still inside the synchronizer.
        step(0, 1); step(0, 0); step(0, 0);
        step(1, 0); step(0, 1);
        repeat (5) step(0, 0);

        // Randomized traffic with sparse starts and occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 11) == 0), ($urandom_range(0, 24) == 0));
        end
        repeat (4) step(0, 0);

        @(posedge clk);
        #2;
        n_vec++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_start_reg_flag
`default_nettype wire
